// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: bus width defaults and FSM states.
package mem_arbiter_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

    // Encoding 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, on contention the port that was not served last wins.
module mem_arbiter_rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic sel
);

    // Combinational winner select.
    always_comb begin
        grant = req0 | req1;
        sel   = req1 & (~req0 | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between two masters, serialising accesses with round-robin priority
// and aborting any access that memory never acknowledges.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_t        state;
    state_t        state_next;
    logic          sel;
    logic          sel_next;
    logic          last;
    logic          last_next;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_next;
    logic [DW-1:0] rdata_next;
    logic          mem_req_next;
    logic          mem_w_next;
    logic [AW-1:0] mem_addr_next;
    logic [DW-1:0] mem_wdata_next;
    logic          ack0_next;
    logic          ack1_next;
    logic          err0_next;
    logic          err1_next;
    logic          pick_grant;
    logic          pick_sel;

    mem_arbiter_rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (pick_grant),
        .sel   (pick_sel)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus next values of every registered output; the memory-side registers double as the request latch.
    always_comb begin
        state_next     = state;
        sel_next       = sel;
        last_next      = last;
        cnt_next       = cnt;
        rdata_next     = rdata;
        mem_req_next   = 1'b0;
        mem_w_next     = 1'b0;
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        ack0_next      = 1'b0;
        ack1_next      = 1'b0;
        err0_next      = 1'b0;
        err1_next      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_grant) begin
                    state_next     = BUSY;
                    sel_next       = pick_sel;
                    cnt_next       = '0;
                    mem_req_next   = 1'b1;
                    mem_w_next     = pick_sel ? we1 : we0;
                    mem_addr_next  = pick_sel ? addr1 : addr0;
                    mem_wdata_next = pick_sel ? wdata1 : wdata0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next = DONE;
                    if (!mem_w) begin
                        rdata_next = mem_rdata;
                    end
                    ack0_next = ~sel;
                    ack1_next = sel;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    state_next = DONE;
                    rdata_next = '0;
                    err0_next  = ~sel;
                    err1_next  = sel;
                end else begin
                    cnt_next       = cnt + TW'(1);
                    mem_req_next   = 1'b1;
                    mem_w_next     = mem_w;
                    mem_addr_next  = mem_addr;
                    mem_wdata_next = mem_wdata;
                end
            end
            DONE: begin
                state_next = IDLE;
                last_next  = sel;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_w     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
        end else begin
            sel       <= sel_next;
            last      <= last_next;
            cnt       <= cnt_next;
            rdata     <= rdata_next;
            mem_req   <= mem_req_next;
            mem_w     <= mem_w_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            ack0      <= ack0_next;
            ack1      <= ack1_next;
            err0      <= err0_next;
            err1      <= err1_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: the bench plays both masters and the memory,
// predicts each access outcome and its cycle from the arbitration rules, and a monitor checks it.
module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;
    localparam int unsigned TW = 8;

    typedef struct {
        int          port;
        bit          is_err;
        logic [15:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    logic          clk;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, err0, err1;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          m_req   [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];

    assign req0   = m_req[0];
    assign req1   = m_req[1];
    assign we0    = m_we[0];
    assign we1    = m_we[1];
    assign addr0  = m_addr[0];
    assign addr1  = m_addr[1];
    assign wdata0 = m_wdata[0];
    assign wdata1 = m_wdata[1];

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .err0      (err0),
        .err1      (err1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_w     (mem_w),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    int          cyc;
    int          free_edge;
    int          busy_lo;
    int          busy_hi;
    int          ready_c;
    int          rel_c [2];
    bit          pend [2];
    bit          granted [2];
    bit          last_port;
    bit          exp_busy;
    logic [15:0] model_rdata;
    logic [15:0] rd_val;
    logic [15:0] mem_model [0:65535];
    resp_t       sb [$];
    acc_t        acc_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
    endtask

    task automatic new_fields(input int p);
        m_we[p]    = 1'($urandom);
        m_addr[p]  = ($urandom % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        m_wdata[p] = 16'($urandom);
    endtask

    task automatic reset_model();
        sb.delete();
        acc_q.delete();
        free_edge   = 0;
        busy_lo     = -1;
        busy_hi     = -2;
        ready_c     = -1;
        last_port   = 1'b1;
        model_rdata = '0;
        exp_busy    = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        for (int p = 0; p < 2; p++) begin
            m_req[p]   = 1'b0;
            pend[p]    = 1'b0;
            granted[p] = 1'b0;
            rel_c[p]   = -1;
        end
    endtask

    // Arbitration decision on the request lines the DUT just sampled.
    task automatic grant(input bit d0);
        int    p;
        int    d;
        resp_t r;
        acc_t  a;
        if (m_req[0] && m_req[1]) p = last_port ? 0 : 1;
        else                      p = m_req[1] ? 1 : 0;
        last_port = (p == 1);
        d = d0 ? 0 : int'($urandom_range(0, TO + 1));
        a.we    = m_we[p];
        a.addr  = m_addr[p];
        a.wdata = m_wdata[p];
        r.port  = p;
        busy_lo = cyc;
        if (d < int'(TO)) begin
            r.is_err = 1'b0;
            busy_hi  = cyc + d;
            ready_c  = cyc + d;
            if (a.we) begin
                mem_model[a.addr] = a.wdata;
                rd_val = 16'($urandom);
            end else begin
                rd_val      = mem_model[a.addr];
                model_rdata = rd_val;
            end
        end else begin
            r.is_err    = 1'b1;
            busy_hi     = cyc + int'(TO) - 1;
            ready_c     = -1;
            model_rdata = '0;
        end
        r.rdata    = model_rdata;
        r.due      = busy_hi + 1;
        free_edge  = busy_hi + 3;
        rel_c[p]   = busy_hi + 2;
        granted[p] = 1'b1;
        sb.push_back(r);
        acc_q.push_back(a);
    endtask

    // One clock: model the arbitration edge, then drive masters and memory for the new cycle.
    task automatic step(input int p_new, input int p_rereq, input bit d0);
        tick();
        if (!rst && cyc >= free_edge && (m_req[0] || m_req[1])) grant(d0);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (pend[p] && cyc == rel_c[p]) begin
                granted[p] = 1'b0;
                rel_c[p]   = -1;
                if (int'($urandom_range(0, 99)) < p_rereq) begin
                    new_fields(p);
                end else begin
                    m_req[p] = 1'b0;
                    pend[p]  = 1'b0;
                end
            end else if (!pend[p]) begin
                if (int'($urandom_range(0, 99)) < p_new) begin
                    new_fields(p);
                    m_req[p] = 1'b1;
                    pend[p]  = 1'b1;
                end
            end else if (granted[p] && $urandom_range(0, 3) == 0) begin
                new_fields(p);
            end
        end
        exp_busy = (cyc >= busy_lo && cyc <= busy_hi);
        if (cyc == ready_c) begin
            mem_ready = 1'b1;
            mem_rdata = rd_val;
        end else begin
            mem_ready = exp_busy ? 1'b0 : 1'($urandom);
            mem_rdata = 16'($urandom);
        end
    endtask

    // Pops the scoreboard on every ack/err pulse and checks the memory side each cycle.
    task automatic run_monitor();
        resp_t r;
        acc_t  a;
        int    n;
        int    port;
        bit    is_err;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n = int'(ack0) + int'(ack1) + int'(err0) + int'(err1);
                chk("multi_pulse", 32'(n > 1), 32'(0));
                if (n == 1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: ack0=%0b ack1=%0b err0=%0b err1=%0b with nothing outstanding (cycle %0d)",
                                 ack0, ack1, err0, err1, cyc);
                    end else begin
                        r      = sb.pop_front();
                        port   = (ack1 || err1) ? 1 : 0;
                        is_err = err0 || err1;
                        chk("port", 32'(port), 32'(r.port));
                        chk("err_not_ack", 32'(is_err), 32'(r.is_err));
                        chk("rdata", 32'(rdata), 32'(r.rdata));
                        chk("latency", 32'(cyc), 32'(r.due));
                        if (acc_q.size() > 0) void'(acc_q.pop_front());
                    end
                end
                chk("mem_req", 32'(mem_req), 32'(exp_busy));
                if (mem_req && acc_q.size() > 0) begin
                    a = acc_q[0];
                    chk("mem_w", 32'(mem_w), 32'(a.we));
                    chk("mem_addr", 32'(mem_addr), 32'(a.addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(a.wdata));
                end else if (!mem_req) begin
                    chk("idle_bus_zero", 32'(mem_w || mem_addr != '0 || mem_wdata != '0), 32'(0));
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'(0));
        chk({tag, "_mem_w"}, 32'(mem_w), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        chk({tag, "_pulses"}, 32'({ack0, ack1, err0, err1}), 32'(0));
        chk({tag, "_rdata"}, 32'(rdata), 32'(0));
    endtask

    task automatic start_contention();
        for (int p = 0; p < 2; p++) begin
            new_fields(p);
            m_req[p] = 1'b1;
            pend[p]  = 1'b1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int i = 0; i < 65536; i++) mem_model[i] = '0;
        for (int p = 0; p < 2; p++) begin
            m_we[p]    = 1'b0;
            m_addr[p]  = '0;
            m_wdata[p] = '0;
        end
        reset_model();
        rst = 1'b1;
        fork
            run_monitor();
        join_none

        tick();
        tick();
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Saturated contention straight out of reset: 0,1,0,1 every 3 cycles.
        start_contention();
        for (int k = 0; k < 14; k++) step(0, 100, 1'b1);

        // Mixed random traffic with random memory latency and timeouts.
        for (int k = 0; k < 2500; k++) step(30, 50, 1'b0);

        // Asynchronous reset in the middle of an access.
        for (int k = 0; k < 200 && !exp_busy; k++) step(40, 50, 1'b0);
        chk("busy_before_reset", 32'(mem_req), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        reset_model();
        tick();
        #1;
        rst = 1'b0;

        // First contention after reset goes to port 0 again.
        start_contention();
        for (int k = 0; k < 12; k++) step(0, 100, 1'b1);

        // Drain outstanding work with no new requests.
        for (int k = 0; k < 40; k++) step(0, 0, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
